// File: rtl/issue_scheduler.sv
// Wakeup/select between the reservation station and ALU0, ALU1 and the memory unit.
// Latency: requests sampled at edge t appear on instr_ready/idx/issue_clear at edge t+1.
// Backpressure: ALUs never stall; the memory unit accepts one op and then blocks until mem_done.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   entry_valid     RS slot occupied (one bit per entry)
//   entry_ready     both source operands available
//   entry_is_mem    slot holds a load/store, else an ALU op
//   entry_age       age tag per entry, entry i at [i*AGE_W +: AGE_W]
//   head_age        age tag of the ROB head; ages are compared relative to it
//   flush           synchronous flush: kills grants and any outstanding memory op
//   mem_done        memory unit finished its outstanding op
//   instr_ready     [0]=ALU0, [1]=ALU1, [2]=MEM issue pulse
//   alu0_idx, alu1_idx, mem_idx   RS index per unit, held when the unit's bit is 0
//   issue_clear     one-hot-per-grant clear back to the RS
//   mem_busy        memory op outstanding
//
// Optional build macro ISSUE_PERF_CNT_EN adds perf_issued (total grants) and
// perf_idle (cycles with eligible work but no grant) counters.

module issue_scheduler #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int AGE_W       = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_ENTRIES-1:0]   entry_valid,
  input  logic [NUM_ENTRIES-1:0]   entry_ready,
  input  logic [NUM_ENTRIES-1:0]   entry_is_mem,
  input  logic [NUM_ENTRIES*AGE_W-1:0] entry_age,
  input  logic [AGE_W-1:0]         head_age,
  input  logic                     flush,
  input  logic                     mem_done,
  output logic [2:0]               instr_ready,
  output logic [IDX_W-1:0]         alu0_idx,
  output logic [IDX_W-1:0]         alu1_idx,
  output logic [IDX_W-1:0]         mem_idx,
  output logic [NUM_ENTRIES-1:0]   issue_clear,
`ifdef ISSUE_PERF_CNT_EN
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_idle,
`endif
  output logic                     mem_busy
);

  typedef enum logic {M_IDLE = 1'b0, M_WAIT = 1'b1} mstate_t;

  mstate_t state_q, state_d;

  // Eligibility. issue_clear is the registered clear still travelling to the
  // RS, so last cycle's grants are masked until the RS has dropped them.
  logic [NUM_ENTRIES-1:0] alu_elig;
  logic [NUM_ENTRIES-1:0] mem_elig;

  assign alu_elig = entry_valid & entry_ready & ~entry_is_mem & ~issue_clear;
  assign mem_elig = entry_valid & entry_ready &  entry_is_mem & ~issue_clear;

  // Age relative to the ROB head; modular subtraction handles tag wrap.
  logic [AGE_W-1:0] rel_age [NUM_ENTRIES];

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rel_age[i] = entry_age[i*AGE_W +: AGE_W] - head_age;
    end
  end

  // Oldest / second-oldest ALU entry and oldest memory entry. Scanning in
  // ascending index order with a strict less-than keeps ties on the lower index.
  logic             a0_found, a1_found, m_found;
  logic [IDX_W-1:0] a0_sel, a1_sel, m_sel;
  logic [AGE_W-1:0] a0_age, a1_age, m_age;

  always_comb begin
    a0_found = 1'b0;
    a0_sel   = '0;
    a0_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alu_elig[i] && (!a0_found || rel_age[i] < a0_age)) begin
        a0_found = 1'b1;
        a0_sel   = IDX_W'(i);
        a0_age   = rel_age[i];
      end
    end
  end

  always_comb begin
    a1_found = 1'b0;
    a1_sel   = '0;
    a1_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alu_elig[i] && (IDX_W'(i) != a0_sel) &&
          (!a1_found || rel_age[i] < a1_age)) begin
        a1_found = 1'b1;
        a1_sel   = IDX_W'(i);
        a1_age   = rel_age[i];
      end
    end
  end

  always_comb begin
    m_found = 1'b0;
    m_sel   = '0;
    m_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (mem_elig[i] && (!m_found || rel_age[i] < m_age)) begin
        m_found = 1'b1;
        m_sel   = IDX_W'(i);
        m_age   = rel_age[i];
      end
    end
  end

  // Grants. a1 can only be found when a0 was, since a1 excludes a0's index.
  // The memory unit issues only from M_IDLE, so a mem_done arriving with a
  // waiting entry costs one bubble cycle before that entry goes out.
  logic                   alu0_gnt, alu1_gnt, mem_gnt;
  logic [NUM_ENTRIES-1:0] clear_d;

  assign alu0_gnt = a0_found & ~flush;
  assign alu1_gnt = a1_found & ~flush;
  assign mem_gnt  = m_found & (state_q == M_IDLE) & ~flush;

  always_comb begin
    clear_d = '0;
    if (alu0_gnt) clear_d = clear_d | (NUM_ENTRIES'(1) << a0_sel);
    if (alu1_gnt) clear_d = clear_d | (NUM_ENTRIES'(1) << a1_sel);
    if (mem_gnt)  clear_d = clear_d | (NUM_ENTRIES'(1) << m_sel);
  end

  // Memory FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= M_IDLE;
    else        state_q <= state_d;
  end

  // Memory FSM: next state. flush wins over both a grant and mem_done.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = M_IDLE;
    end else begin
      case (state_q)
        M_IDLE:  if (mem_gnt)  state_d = M_WAIT;
        M_WAIT:  if (mem_done) state_d = M_IDLE;
        default: state_d = M_IDLE;
      endcase
    end
  end

  // Memory FSM: outputs
  always_comb begin
    mem_busy = (state_q == M_WAIT);
  end

  // Registered issue outputs. Index registers only load on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready <= '0;
      alu0_idx    <= '0;
      alu1_idx    <= '0;
      mem_idx     <= '0;
      issue_clear <= '0;
    end else begin
      instr_ready <= {mem_gnt, alu1_gnt, alu0_gnt};
      issue_clear <= clear_d;
      if (alu0_gnt) alu0_idx <= a0_sel;
      if (alu1_gnt) alu1_idx <= a1_sel;
      if (mem_gnt)  mem_idx  <= m_sel;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Counters are not cleared by flush; a flushed cycle has no grants and is
  // not counted as idle since nothing was allowed to issue.
  logic any_elig;
  logic any_gnt;

  assign any_elig = (|alu_elig) | (|mem_elig);
  assign any_gnt  = alu0_gnt | alu1_gnt | mem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_idle   <= '0;
    end else begin
      perf_issued <= perf_issued + 32'(alu0_gnt) + 32'(alu1_gnt) + 32'(mem_gnt);
      if (any_elig && !any_gnt && !flush) perf_idle <= perf_idle + 32'd1;
    end
  end
`endif

endmodule
